// File: rtl/bios_loader.sv
// HPS ioctl download to Next186 BIOS RAM bridge: filters by index, buffers words in a
// small FIFO, writes them under the BIOS_REQ busy handshake and holds the CPU in reset.
module bios_loader #(
  parameter int unsigned ADDR_W     = 13,
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter int unsigned HOLD_CYC   = 16,
  parameter int unsigned ROM_INDEX  = 0
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [15:0]       ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [15:0]       ioctl_dout,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] bios_addr,
  output logic [15:0]       bios_din,
  output logic              bios_wr,
  input  logic              bios_req,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              overflow,
  output logic [15:0]       checksum
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned CntW  = $clog2(HOLD_CYC + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StHold} state_e;

  state_e                 state_q;
  logic [CntW-1:0]        hold_cnt_q;
  logic                   sel_q;
  logic [ADDR_W+15:0]     mem [Depth];
  logic [DEPTH_LOG2-1:0]  wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]    count_q;

  logic               sel, sel_rise, push, in_range, full, push_ok, pop, clear;
  logic [ADDR_W+15:0] head;

  assign sel      = ioctl_download && (ioctl_index == 16'(ROM_INDEX));
  assign sel_rise = sel && !sel_q;
  assign push     = sel && ioctl_wr;
  assign in_range = ((ioctl_addr >> (ADDR_W + 1)) == '0);
  assign full     = (count_q == (DEPTH_LOG2 + 1)'(Depth));
  assign push_ok  = push && in_range && !full;
  assign pop      = (count_q != '0) && !bios_req;
  assign head     = mem[rd_ptr_q];
  assign clear    = (state_q == StIdle) && sel_rise;

  // One slot of headroom: HPS may already have a write in flight when it sees wait.
  assign ioctl_wait = (count_q >= (DEPTH_LOG2 + 1)'(Depth - 1));

  always_ff @(posedge clk_sys) begin
    if (push_ok) mem[wr_ptr_q] <= {ioctl_addr[ADDR_W:1], ioctl_dout};
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= StIdle;
      hold_cnt_q <= '0;
      sel_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      bios_addr  <= '0;
      bios_din   <= '0;
      bios_wr    <= 1'b0;
      cpu_reset  <= 1'b0;
      load_done  <= 1'b0;
      overflow   <= 1'b0;
      checksum   <= '0;
    end else begin
      sel_q     <= sel;
      bios_wr   <= pop;
      load_done <= 1'b0;

      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        bios_addr <= head[ADDR_W+15:16];
        bios_din  <= head[15:0];
      end
      unique case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      checksum <= (clear ? 16'h0 : checksum) + (pop ? head[15:0] : 16'h0);
      overflow <= (clear ? 1'b0 : overflow) | (push && (!in_range || full));

      unique case (state_q)
        StIdle: begin
          if (sel_rise) begin
            state_q   <= StLoad;
            cpu_reset <= 1'b1;
          end
        end
        StLoad: begin
          if (!sel) state_q <= StDrain;
        end
        StDrain: begin
          if (sel_rise) begin
            state_q <= StLoad;
          end else if (count_q == '0) begin
            state_q    <= StHold;
            hold_cnt_q <= CntW'(HOLD_CYC - 1);
          end
        end
        StHold: begin
          // Leave as the count reaches zero so cpu_reset falls HOLD_CYC after the last write.
          if (sel_rise) begin
            state_q <= StLoad;
          end else if (hold_cnt_q <= CntW'(1)) begin
            state_q    <= StIdle;
            hold_cnt_q <= '0;
            cpu_reset  <= 1'b0;
            load_done  <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
